// File: rtl/mailbox_pkg.sv
// mailbox_pkg: register map, STATUS bit positions and default pass code for result_mailbox.
package mailbox_pkg;
    typedef enum logic [1:0] {
        OFF_DATA   = 2'd0,
        OFF_STATUS = 2'd1,
        OFF_DONE   = 2'd2,
        OFF_COUNT  = 2'd3
    } reg_off_e;
    localparam int ST_OVF   = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_EMPTY = 5;
    localparam int ST_DONE  = 4;
    localparam int ST_PASS  = 3;
    localparam logic [7:0] DEF_PASS_CODE = 8'h1F;
endpackage

// File: rtl/mailbox_fifo.sv
// mailbox_fifo: DEPTH-entry synchronous byte FIFO; head is masked to 0 when empty.
module mailbox_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          ph2,
    input  logic          resetb,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        do_push, do_pop;
    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign count = count_q;
    assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
    // A push into a full FIFO only lands when the same edge frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge ph2) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/result_mailbox.sv
// result_mailbox: 6502 bus register window that streams bytes to a bench FIFO and latches a pass/fail code.
module result_mailbox
    import mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hE000,
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  PASS_CODE = DEF_PASS_CODE
) (
    input  logic        ph2,
    input  logic        resetb,
    input  logic [15:0] address,
    input  logic [7:0]  data_in,
    input  logic        memwrite,
    input  logic        memread,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic        pass,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    reg_off_e    off;
    logic [AW:0] count;
    logic        full, empty, wr, push, pop, done_wr;
    logic        done_q, done_d, pass_q, pass_d, overflow_q, overflow_d;
    logic [7:0]  done_val_q, done_val_d, status;
    assign sel       = address[15:2] == BASE_ADDR[15:2];
    assign off       = reg_off_e'(address[1:0]);
    assign wr        = sel & memwrite;
    assign push      = wr && off == OFF_DATA;
    assign pop       = out_ready & ~empty;
    assign done_wr   = wr && off == OFF_DONE && !done_q;
    assign out_valid = ~empty;
    assign done      = done_q;
    assign pass      = pass_q;
    assign overflow  = overflow_q;
    mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .ph2    (ph2),
        .resetb (resetb),
        .push   (push),
        .pop    (pop),
        .wdata  (data_in),
        .rdata  (out_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );
    always_comb begin
        done_d     = done_q | done_wr;
        pass_d     = done_wr ? data_in == PASS_CODE : pass_q;
        done_val_d = done_wr ? data_in : done_val_q;
        overflow_d = overflow_q | (push & full & ~pop);
    end
    always_comb begin
        status           = 8'h00;
        status[ST_OVF]   = overflow_q;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_DONE]  = done_q;
        status[ST_PASS]  = pass_q;
        data_out = !(sel && memread)  ? 8'h00 :
                   off == OFF_STATUS ? status :
                   off == OFF_DONE   ? done_val_q :
                   off == OFF_COUNT  ? 8'(count) : 8'h00;
    end
    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_val_q <= 8'h00;
        end else begin
            done_q     <= done_d;
            pass_q     <= pass_d;
            overflow_q <= overflow_d;
            done_val_q <= done_val_d;
        end
    end
endmodule

// File: tb/tb_result_mailbox.sv
// tb_result_mailbox: directed checks of the mailbox register window, FIFO stream and sticky flags.
module tb_result_mailbox;
    logic        ph2 = 1'b0;
    logic        resetb = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  data_out, out_data;
    logic        sel, out_valid, done, pass, overflow;
    int          tests = 0;
    int          failed = 0;
    logic [7:0]  rd;
    logic [7:0]  exp_q [8];

    result_mailbox dut (
        .ph2       (ph2),
        .resetb    (resetb),
        .address   (address),
        .data_in   (data_in),
        .memwrite  (memwrite),
        .memread   (memread),
        .data_out  (data_out),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .pass      (pass),
        .overflow  (overflow)
    );

    always #5 ph2 = ~ph2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge ph2);
        address  = a;
        data_in  = d;
        memwrite = 1'b1;
        @(posedge ph2);
        #1;
        memwrite = 1'b0;
        address  = 16'h0000;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
        address = a;
        memread = 1'b1;
        #1;
        d = data_out;
        memread = 1'b0;
        address = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge ph2);
        resetb = 1'b0;
        #2;
        resetb = 1'b1;
    endtask

    initial begin
        // reset state
        #12 resetb = 1'b1;
        cpu_rd(16'hE001, rd); chk("reset_status", rd, 8'h20);
        cpu_rd(16'hE003, rd); chk("reset_count", rd, 8'h00);
        chk("reset_valid", {7'b0, out_valid}, 8'h00);
        chk("reset_done", {7'b0, done}, 8'h00);
        chk("reset_out_data", out_data, 8'h00);
        // single push, then pop
        cpu_wr(16'hE000, 8'hA5);
        chk("push_valid", {7'b0, out_valid}, 8'h01);
        chk("push_data", out_data, 8'hA5);
        cpu_rd(16'hE003, rd); chk("push_count", rd, 8'h01);
        cpu_rd(16'hE000, rd); chk("data_read_zero", rd, 8'h00);
        address = 16'hE004; memread = 1'b1; #1;
        chk("out_of_window_sel", {7'b0, sel}, 8'h00);
        chk("out_of_window_data", data_out, 8'h00);
        memread = 1'b0; address = 16'h0000;
        @(negedge ph2); out_ready = 1'b1;
        @(posedge ph2); #1; out_ready = 1'b0;
        chk("pop_valid", {7'b0, out_valid}, 8'h00);
        // overflow: 9 pushes into 8 slots
        for (int i = 1; i <= 9; i++) cpu_wr(16'hE000, 8'(i));
        cpu_rd(16'hE003, rd); chk("ovf_count", rd, 8'h08);
        cpu_rd(16'hE001, rd); chk("ovf_status", rd, 8'hC0);
        chk("ovf_flag", {7'b0, overflow}, 8'h01);
        @(negedge ph2); out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_%0d", i), out_data, 8'(i));
            @(posedge ph2); #1;
        end
        out_ready = 1'b0;
        chk("drain_empty", {7'b0, out_valid}, 8'h00);
        // full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) cpu_wr(16'hE000, 8'h10 + 8'(i));
        out_ready = 1'b1;
        cpu_wr(16'hE000, 8'h55);
        out_ready = 1'b0;
        cpu_rd(16'hE003, rd); chk("pp_count", rd, 8'h08);
        chk("pp_no_ovf", {7'b0, overflow}, 8'h00);
        for (int i = 0; i < 7; i++) exp_q[i] = 8'h11 + 8'(i);
        exp_q[7] = 8'h55;
        @(negedge ph2); out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain_%0d", i), out_data, exp_q[i]);
            @(posedge ph2); #1;
        end
        out_ready = 1'b0;
        chk("pp_empty", {7'b0, out_valid}, 8'h00);
        // DONE with pass code, then ignored rewrite
        cpu_wr(16'hE002, 8'h1F);
        chk("done_set", {7'b0, done}, 8'h01);
        chk("pass_set", {7'b0, pass}, 8'h01);
        cpu_rd(16'hE001, rd); chk("done_status", rd, 8'h38);
        cpu_rd(16'hE002, rd); chk("done_readback", rd, 8'h1F);
        cpu_wr(16'hE002, 8'h00);
        chk("pass_sticky", {7'b0, pass}, 8'h01);
        // DONE with fail code
        do_reset();
        cpu_rd(16'hE002, rd); chk("done_val_reset", rd, 8'h00);
        cpu_wr(16'hE002, 8'h00);
        chk("fail_done", {7'b0, done}, 8'h01);
        chk("fail_pass", {7'b0, pass}, 8'h00);
        cpu_rd(16'hE001, rd); chk("fail_status", rd, 8'h30);
        // asynchronous reset mid-stream
        do_reset();
        cpu_wr(16'hE002, 8'h1F);
        for (int i = 1; i <= 9; i++) cpu_wr(16'hE000, 8'(i));
        #1 resetb = 1'b0;
        #1;
        chk("arst_valid", {7'b0, out_valid}, 8'h00);
        chk("arst_flags", {5'b0, done, pass, overflow}, 8'h00);
        chk("arst_out_data", out_data, 8'h00);
        cpu_rd(16'hE003, rd); chk("arst_count", rd, 8'h00);
        @(negedge ph2); resetb = 1'b1;
        cpu_wr(16'hE000, 8'h77);
        chk("post_rst_data", out_data, 8'h77);
        cpu_rd(16'hE003, rd); chk("post_rst_count", rd, 8'h01);
        @(negedge ph2); out_ready = 1'b1;
        @(posedge ph2); #1; out_ready = 1'b0;
        chk("post_rst_empty", {7'b0, out_valid}, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
